// File: rtl/adder3_accum_seq_if.sv
// rtl/adder3_accum_seq_if.sv - start, term-pair, external adder and result bundle for adder3_accum_seq
interface adder3_accum_seq_if #(
  parameter int DW = 16
);
  logic          start;
  logic [DW-1:0] bias;
  logic          busy;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_a;
  logic [DW-1:0] in_b;
  logic [DW-1:0] add_a;
  logic [DW-1:0] add_b;
  logic [DW-1:0] add_c;
  logic [DW-1:0] add_sum;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;

  // master: the environment (multiplier stage, adder, sigmoid stage)
  modport master (
    output start, bias, in_valid, in_a, in_b, add_sum, out_ready,
    input  busy, in_ready, add_a, add_b, add_c, out_valid, out_data
  );

  // slave: the sequencer
  modport slave (
    input  start, bias, in_valid, in_a, in_b, add_sum, out_ready,
    output busy, in_ready, add_a, add_b, add_c, out_valid, out_data
  );
endinterface

// File: rtl/adder3_accum_seq.sv
// rtl/adder3_accum_seq.sv - time-shares one 3-input adder to form bias + sum of N_TERMS products
module adder3_accum_seq #(
  parameter int DW      = 16,
  parameter int N_TERMS = 9
) (
  input  logic               clk,
  input  logic               rst_n,
  adder3_accum_seq_if.slave  bus
);
  localparam int BEATS = (N_TERMS + 1) / 2;
  localparam int CW    = $clog2(BEATS) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(BEATS - 1);
  localparam bit   ODD_N = (N_TERMS % 2) == 1;

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;

  state_t        state, state_nxt;
  logic [DW-1:0] acc, acc_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          last_beat;

  assign last_beat = (cnt == LAST_CNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          acc_nxt   = bus.bias;
          cnt_nxt   = '0;
          state_nxt = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (bus.in_valid) begin
          acc_nxt = bus.add_sum;
          cnt_nxt = cnt + 1'b1;
          if (last_beat) state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign bus.busy      = (state != S_IDLE);
  assign bus.in_ready  = (state == S_ACCUM);
  assign bus.out_valid = (state == S_DONE);
  assign bus.out_data  = acc;
  assign bus.add_a     = acc;
  assign bus.add_b     = bus.in_a;
  // Odd term count: the last beat carries a single term, so the pair's second slot is zeroed.
  assign bus.add_c     = (ODD_N && state == S_ACCUM && last_beat) ? '0 : bus.in_b;
endmodule

// File: tb/tb_adder3_accum_seq.sv
// tb/tb_adder3_accum_seq.sv - randomized self-checking bench for adder3_accum_seq at N_TERMS 9, 4, 2, 1
module tb_adder3_accum_seq;
  localparam int NI = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_s    [NI];
  logic [15:0] bias_s     [NI];
  logic        in_valid_s [NI];
  logic [15:0] in_a_s     [NI];
  logic [15:0] in_b_s     [NI];
  logic        out_ready_s[NI];
  logic        busy_o     [NI];
  logic        in_ready_o [NI];
  logic        out_valid_o[NI];
  logic [15:0] add_a_o    [NI];
  logic [15:0] add_b_o    [NI];
  logic [15:0] add_c_o    [NI];
  logic [15:0] out_data_o [NI];

  int checks = 0;
  int errors = 0;
  logic [15:0] terms_q[$];
  int obs_addc_bad;
  int obs_hold_bad;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    adder3_accum_seq_if #(.DW(16)) bus ();
    assign bus.start     = start_s[g];
    assign bus.bias      = bias_s[g];
    assign bus.in_valid  = in_valid_s[g];
    assign bus.in_a      = in_a_s[g];
    assign bus.in_b      = in_b_s[g];
    assign bus.out_ready = out_ready_s[g];
    assign bus.add_sum   = bus.add_a + bus.add_b + bus.add_c;
    assign busy_o[g]      = bus.busy;
    assign in_ready_o[g]  = bus.in_ready;
    assign out_valid_o[g] = bus.out_valid;
    assign add_a_o[g]     = bus.add_a;
    assign add_b_o[g]     = bus.add_b;
    assign add_c_o[g]     = bus.add_c;
    assign out_data_o[g]  = bus.out_data;
    adder3_accum_seq #(.DW(16), .N_TERMS(g == 0 ? 9 : g == 1 ? 4 : g == 2 ? 2 : 1)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
    );
  end

  function automatic int nt(input int k);
    return (k == 0) ? 9 : (k == 1) ? 4 : (k == 2) ? 2 : 1;
  endfunction

  // Reference: bias plus the first n terms, wrapped to 16 bits.
  function automatic logic [15:0] ref_sum(input logic [15:0] b, input int n);
    logic [15:0] s;
    s = b;
    for (int j = 0; j < n; j++) s = s + terms_q[j];
    return s;
  endfunction

  task automatic fill_random(input int n);
    terms_q.delete();
    for (int j = 0; j < n; j++) terms_q.push_back(16'($urandom));
  endtask

  // Drives start then all beats; returns at the negedge where out_valid should be high.
  task automatic run_neuron(input int k, input logic [15:0] b, input bit gap,
                            output logic [15:0] res, output int lat, output bit tout);
    int  n, beats, i, cyc;
    bit  phase, v;
    logic [15:0] exp_c, prev_a;
    n = nt(k); beats = (n + 1) / 2;
    i = 0; cyc = 0; phase = 1'b1; tout = 1'b0; lat = 0;
    obs_addc_bad = 0; obs_hold_bad = 0;
    start_s[k] = 1'b1; bias_s[k] = b; in_valid_s[k] = 1'b0;
    @(negedge clk); lat++;
    start_s[k] = 1'b0;
    while (i < beats) begin
      v = gap ? phase : 1'b1;
      phase = !phase;
      in_valid_s[k] = v;
      in_a_s[k] = terms_q[2*i];
      in_b_s[k] = (2*i + 1 < n) ? terms_q[2*i+1] : 16'h7FFF;
      #1;
      exp_c = (2*i + 1 < n) ? terms_q[2*i+1] : 16'h0000;
      if (v && add_c_o[k] !== exp_c) obs_addc_bad++;
      prev_a = add_a_o[k];
      @(negedge clk); lat++;
      if (v) i++;
      else if (add_a_o[k] !== prev_a) obs_hold_bad++;
      cyc++;
      if (cyc > 100) begin tout = 1'b1; break; end
    end
    in_valid_s[k] = 1'b0;
    if (!out_valid_o[k]) tout = 1'b1;
    res = out_data_o[k];
  endtask

  task automatic accept(input int k);
    out_ready_s[k] = 1'b1;
    @(negedge clk);
    out_ready_s[k] = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < NI; k++) begin
      in_a_s[k] = 16'($urandom); in_b_s[k] = 16'($urandom);
      #1;
      checks++;
      if (busy_o[k] !== 1'b0 || in_ready_o[k] !== 1'b0 || out_valid_o[k] !== 1'b0) begin
        errors++; $display("FAIL reset_ctrl[%0d] busy=%b in_ready=%b out_valid=%b required 0 0 0", k, busy_o[k], in_ready_o[k], out_valid_o[k]);
      end
      checks++;
      if (out_data_o[k] !== 16'h0 || add_a_o[k] !== 16'h0) begin
        errors++; $display("FAIL reset_data[%0d] out_data=%h add_a=%h required 0000", k, out_data_o[k], add_a_o[k]);
      end
      checks++;
      if (add_b_o[k] !== in_a_s[k] || add_c_o[k] !== in_b_s[k]) begin
        errors++; $display("FAIL reset_pass[%0d] add_b=%h add_c=%h required %h %h", k, add_b_o[k], add_c_o[k], in_a_s[k], in_b_s[k]);
      end
    end
    @(negedge clk); rst_n = 1'b1; @(negedge clk);
  endtask

  task automatic test_basic;
    logic [15:0] r; int lat; bit tout;
    terms_q.delete();
    for (int j = 0; j < 9; j++) terms_q.push_back(16'h0010);
    run_neuron(0, 16'h0100, 1'b0, r, lat, tout);
    checks++;
    if (tout || r !== 16'h0190) begin
      errors++; $display("FAIL basic_sum got %h timeout=%0d required 0190", r, tout);
    end
    checks++;
    if (lat !== 6) begin errors++; $display("FAIL basic_latency got %0d required 6", lat); end
    checks++;
    if (obs_addc_bad !== 0) begin errors++; $display("FAIL basic_addc_zero bad beats %0d required 0", obs_addc_bad); end
    checks++;
    if (in_ready_o[0] !== 1'b0) begin errors++; $display("FAIL basic_in_ready_done got %b required 0", in_ready_o[0]); end
    accept(0);
  endtask

  task automatic test_wrap;
    logic [15:0] r; int lat; bit tout;
    terms_q = '{16'h0001, 16'h0000, 16'h0000, 16'h0000};
    run_neuron(1, 16'h7FFF, 1'b0, r, lat, tout);
    checks++;
    if (tout || r !== 16'h8000) begin errors++; $display("FAIL wrap_sum got %h timeout=%0d required 8000", r, tout); end
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL wrap_latency got %0d required 3", lat); end
    accept(1);
  endtask

  task automatic test_gap;
    logic [15:0] r; int lat; bit tout;
    terms_q.delete();
    for (int j = 1; j <= 9; j++) terms_q.push_back(16'(j));
    checks++;
    if (in_ready_o[0] !== 1'b0) begin errors++; $display("FAIL gap_in_ready_idle got %b required 0", in_ready_o[0]); end
    run_neuron(0, 16'h0000, 1'b1, r, lat, tout);
    checks++;
    if (tout || r !== 16'd45) begin errors++; $display("FAIL gap_sum got %0d timeout=%0d required 45", r, tout); end
    checks++;
    if (obs_hold_bad !== 0) begin errors++; $display("FAIL gap_acc_hold changed on %0d idle cycles required 0", obs_hold_bad); end
    checks++;
    if (obs_addc_bad !== 0) begin errors++; $display("FAIL gap_addc bad beats %0d required 0", obs_addc_bad); end
    accept(0);
  endtask

  task automatic test_done_hold;
    logic [15:0] r, exp; int lat; bit tout;
    logic [15:0] b;
    b = 16'($urandom);
    fill_random(9);
    exp = ref_sum(b, 9);
    run_neuron(0, b, 1'b0, r, lat, tout);
    checks++;
    if (tout || r !== exp) begin errors++; $display("FAIL hold_sum got %h timeout=%0d required %h", r, tout, exp); end
    for (int c = 0; c < 4; c++) begin
      start_s[0] = c[0];
      #1;
      checks++;
      if (out_valid_o[0] !== 1'b1 || out_data_o[0] !== exp || in_ready_o[0] !== 1'b0) begin
        errors++; $display("FAIL hold_stable c%0d out_valid=%b out_data=%h in_ready=%b required 1 %h 0", c, out_valid_o[0], out_data_o[0], in_ready_o[0], exp);
      end
      @(negedge clk);
    end
    out_ready_s[0] = 1'b1; start_s[0] = 1'b1;
    @(negedge clk);
    out_ready_s[0] = 1'b0; start_s[0] = 1'b0;
    checks++;
    if (out_valid_o[0] !== 1'b0 || busy_o[0] !== 1'b0) begin
      errors++; $display("FAIL hold_exit out_valid=%b busy=%b required 0 0", out_valid_o[0], busy_o[0]);
    end
    @(negedge clk);
    checks++;
    if (busy_o[0] !== 1'b0) begin errors++; $display("FAIL hold_start_ignored busy=%b required 0", busy_o[0]); end
  endtask

  task automatic test_negative;
    logic [15:0] r; int lat; bit tout;
    terms_q = '{16'hFFF0, 16'hFFF0};
    run_neuron(2, 16'h0000, 1'b0, r, lat, tout);
    checks++;
    if (tout || r !== 16'hFFE0) begin errors++; $display("FAIL neg_sum got %h timeout=%0d required FFE0", r, tout); end
    accept(2);
  endtask

  task automatic test_single;
    logic [15:0] r, b; int lat; bit tout;
    b = 16'($urandom);
    fill_random(1);
    run_neuron(3, b, 1'b0, r, lat, tout);
    checks++;
    if (tout || r !== 16'(b + terms_q[0])) begin
      errors++; $display("FAIL single_sum got %h timeout=%0d required %h", r, tout, 16'(b + terms_q[0]));
    end
    checks++;
    if (lat !== 2 || obs_addc_bad !== 0) begin
      errors++; $display("FAIL single_beat latency=%0d addc_bad=%0d required 2 0", lat, obs_addc_bad);
    end
    accept(3);
  endtask

  task automatic test_back_to_back;
    logic [15:0] r, b, exp; int lat, k; bit tout, gap;
    for (int t = 0; t < 24; t++) begin
      k = $urandom_range(0, NI - 1);
      gap = 1'($urandom);
      b = 16'($urandom);
      fill_random(nt(k));
      exp = ref_sum(b, nt(k));
      run_neuron(k, b, gap, r, lat, tout);
      checks++;
      if (tout || r !== exp || obs_addc_bad !== 0 || obs_hold_bad !== 0) begin
        errors++; $display("FAIL rand_sum t%0d k%0d got %h timeout=%0d addc_bad=%0d hold_bad=%0d required %h", t, k, r, tout, obs_addc_bad, obs_hold_bad, exp);
      end
      accept(k);
    end
  endtask

  task automatic test_midreset;
    logic [15:0] r, b, exp; int lat; bit tout;
    start_s[0] = 1'b1; bias_s[0] = 16'h1234;
    @(negedge clk);
    start_s[0] = 1'b0; in_valid_s[0] = 1'b1;
    in_a_s[0] = 16'h0101; in_b_s[0] = 16'h0202;
    @(negedge clk); @(negedge clk);
    in_valid_s[0] = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (busy_o[0] !== 1'b0 || in_ready_o[0] !== 1'b0 || out_valid_o[0] !== 1'b0 ||
        add_a_o[0] !== 16'h0 || out_data_o[0] !== 16'h0) begin
      errors++; $display("FAIL midreset_async busy=%b in_ready=%b out_valid=%b add_a=%h out_data=%h required all 0", busy_o[0], in_ready_o[0], out_valid_o[0], add_a_o[0], out_data_o[0]);
    end
    @(negedge clk); rst_n = 1'b1; @(negedge clk);
    b = 16'($urandom);
    fill_random(9);
    exp = ref_sum(b, 9);
    run_neuron(0, b, 1'b0, r, lat, tout);
    checks++;
    if (tout || r !== exp) begin errors++; $display("FAIL midreset_fresh got %h timeout=%0d required %h", r, tout, exp); end
    accept(0);
  endtask

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < NI; k++) begin
      start_s[k] = 1'b0; bias_s[k] = '0; in_valid_s[k] = 1'b0;
      in_a_s[k] = '0; in_b_s[k] = '0; out_ready_s[k] = 1'b0;
    end
    @(negedge clk);
    test_reset();
    test_basic();
    test_wrap();
    test_gap();
    test_done_hold();
    test_negative();
    test_single();
    test_back_to_back();
    test_midreset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
